imem_load_ctrl: RTL
===================

// Module: imem_load_ctrl
// PURPOSE
//  Sequencer for the instruction-memory port of the fetch stage. It shares that port
//  between CPU fetch (RUN) and a UART program download (LOAD).
//  On request it freezes the CPU, drains in-flight fetches and assembles UART bytes into
//  32-bit words. It writes those words from address 0 upward, then restarts the CPU at PC 0.
// PARAMETERS
//  ADDR_W        14      word-address width of program memory (matches pc[15:2])
//  TIMEOUT       100000  idle cycles after last byte that end a download
//  DRAIN_CYCLES  2       cycles held in DRAIN before accepting bytes
// PORTS
//  clk          in   1        system clock, all state on rising edge
//  rst          in   1        asynchronous, active-low reset
//  load_req     in   1        level request (switch); rising edge starts a download
//  rx_valid     in   1        one-cycle strobe per received UART byte
//  rx_data      in   8        received byte, valid with rx_valid
//  fetch_addr   in   ADDR_W   word address from the fetch stage (pc[15:2])
//  mem_addr     out  ADDR_W   program memory address
//  mem_wdata    out  32       program memory write data
//  mem_we       out  1        program memory write enable, one cycle per word
//  cpu_hold     out  1        freeze PC and pipeline while high
//  cpu_restart  out  1        one-cycle pulse; fetch reloads PC=0
//  loading      out  1        high whenever state != RUN
//  word_count   out  ADDR_W+1 words written in the current or last download
//  overflow     out  1        sticky: a word arrived with memory already full
// BEHAVIOUR
//  Reset: state=RUN, mem_we=0, mem_wdata=0, cpu_hold=0, cpu_restart=0, word_count=0,
//   overflow=0, byte_idx=0, timer=0, load_req_q=0. Reset mid-download aborts with no write.
//  States: RUN -> DRAIN -> LOAD -> FLUSH -> RESTART -> RUN.
//  RUN:
//   mem_addr=fetch_addr (combinational, zero latency); mem_we=0; rx_valid ignored.
//   load_req & ~load_req_q -> DRAIN. Entering DRAIN clears word_count, overflow,
//   byte_idx and timer.
//  DRAIN:
//   cpu_hold=1 from the first DRAIN cycle. Stay DRAIN_CYCLES cycles, then go to LOAD.
//   rx_valid is dropped.
//  LOAD:
//   rx_valid stores rx_data at bits [8*byte_idx+7 : 8*byte_idx] (little-endian), byte_idx++.
//   On the 4th byte, the next cycle drives mem_we=1 for one cycle, with
//   mem_addr=word_count[ADDR_W-1:0] and mem_wdata=the assembled word. Then word_count++
//   and byte_idx wraps to 0.
//   Memory full (word_count==2**ADDR_W): the write is suppressed, overflow=1,
//   word_count does not change.
//   timer: cleared on every rx_valid; counts only after the first byte. At TIMEOUT-1 -> FLUSH.
//   load_req low -> FLUSH.
//   rx_valid in the same cycle as timer terminal count: the byte is accepted, the timer
//   clears, and the state stays LOAD.
//  FLUSH (1 cycle):
//   byte_idx!=0: write the partial word with the missing upper bytes zero, word_count++
//   (same full-memory rule as LOAD). rx_valid is dropped. Then -> RESTART.
//  RESTART (1 cycle): cpu_restart=1, cpu_hold=1, then -> RUN (cpu_hold=0 next cycle).
//  Zero bytes received: no writes, word_count=0; stays in LOAD until load_req falls.
//  cpu_hold=1 in DRAIN, LOAD, FLUSH and RESTART. Outside LOAD/FLUSH, mem_we is never 1.
// TESTING
//  1 RUN: sweep fetch_addr 0..7 with random rx_valid -> mem_addr==fetch_addr each cycle;
//    mem_we==0; cpu_hold==0.
//  2 load_req rise, bytes 13 00 00 00 93 00 10 00, then idle TIMEOUT cycles ->
//    writes 0x00000013@0 and 0x00100093@1; word_count=2; exactly one cpu_restart pulse;
//    cpu_hold drops the cycle after that pulse.
//  3 Bytes 13 00 00 00 AA, then idle -> FLUSH writes 0x000000AA@1; word_count=2.
//  4 ADDR_W=2, 20 bytes -> 4 writes (@0..3); overflow=1; word_count=4; 5th word not written.
//  5 rx_valid coincident with timer terminal count -> byte stored, no FLUSH that cycle;
//    FLUSH occurs TIMEOUT cycles later.
//  6 rst low after 6 bytes in LOAD -> next edge: state RUN, cpu_hold=0, word_count=0,
//    no mem_we; bytes sent in DRAIN -> absent from memory.

Source files
------------

// File: rtl/imem_load_ctrl.sv
// Instruction-memory port sequencer: shares the program memory between CPU fetch and a
// UART byte-stream download that rebuilds the program from address 0, then restarts the CPU.
module imem_load_ctrl #(
  parameter int ADDR_W       = 14,
  parameter int TIMEOUT      = 100000,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              cpu_restart,
  output logic              loading,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_RESTART = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              cpu_restart_q, cpu_restart_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              overflow_q, overflow_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
  logic              got_byte_q, got_byte_d;
  logic              load_req_q, load_req_d;
  logic              commit_s;
  logic [31:0]       commit_word_s;

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_d       = state_q;
    waddr_d       = waddr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_we_d      = 1'b0;
    cpu_restart_d = 1'b0;
    word_count_d  = word_count_q;
    overflow_d    = overflow_q;
    byte_idx_d    = byte_idx_q;
    word_d        = word_q;
    timer_d       = timer_q;
    drain_cnt_d   = drain_cnt_q;
    got_byte_d    = got_byte_q;
    load_req_d    = load_req;
    commit_s      = 1'b0;
    commit_word_s = 32'h0000_0000;

    case (state_q)
      ST_RUN: begin
        if (load_req && !load_req_q) begin
          state_d      = ST_DRAIN;
          word_count_d = '0;
          overflow_d   = 1'b0;
          byte_idx_d   = 2'd0;
          word_d       = 32'h0000_0000;
          timer_d      = '0;
          drain_cnt_d  = '0;
          got_byte_d   = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_LOAD;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      ST_LOAD: begin
        if (rx_valid) begin
          got_byte_d = 1'b1;
          timer_d    = '0;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            commit_s      = 1'b1;
            commit_word_s = {rx_data, word_q[23:0]};
            word_d        = 32'h0000_0000;
          end else begin
            word_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
          end
        end else if (got_byte_q) begin
          timer_d = timer_q + TW'(1);
        end else begin
          timer_d = timer_q;
        end
        // A byte coinciding with terminal count keeps the download alive.
        if (!load_req || (!rx_valid && got_byte_q && timer_q == TIMER_LAST)) begin
          state_d = ST_FLUSH;
          if (byte_idx_d != 2'd0) begin
            commit_s      = 1'b1;
            commit_word_s = word_d;
            byte_idx_d    = 2'd0;
            word_d        = 32'h0000_0000;
          end else begin
            commit_s = commit_s;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_FLUSH: begin
        state_d       = ST_RESTART;
        cpu_restart_d = 1'b1;
      end
      ST_RESTART: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Word count saturates at full memory; further words only raise overflow.
    if (commit_s) begin
      if (word_count_q[ADDR_W]) begin
        overflow_d = 1'b1;
      end else begin
        mem_we_d     = 1'b1;
        mem_wdata_d  = commit_word_s;
        waddr_d      = word_count_q[ADDR_W-1:0];
        word_count_d = word_count_q + (ADDR_W+1)'(1);
      end
    end else begin
      mem_we_d = 1'b0;
    end

    cpu_hold_d = (state_d != ST_RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      waddr_q       <= '0;
      mem_wdata_q   <= 32'h0000_0000;
      mem_we_q      <= 1'b0;
      cpu_hold_q    <= 1'b0;
      cpu_restart_q <= 1'b0;
      word_count_q  <= '0;
      overflow_q    <= 1'b0;
      byte_idx_q    <= 2'd0;
      word_q        <= 32'h0000_0000;
      timer_q       <= '0;
      drain_cnt_q   <= '0;
      got_byte_q    <= 1'b0;
      load_req_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      waddr_q       <= waddr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_we_q      <= mem_we_d;
      cpu_hold_q    <= cpu_hold_d;
      cpu_restart_q <= cpu_restart_d;
      word_count_q  <= word_count_d;
      overflow_q    <= overflow_d;
      byte_idx_q    <= byte_idx_d;
      word_q        <= word_d;
      timer_q       <= timer_d;
      drain_cnt_q   <= drain_cnt_d;
      got_byte_q    <= got_byte_d;
      load_req_q    <= load_req_d;
    end
  end

  // Fetch owns the address with zero latency while running.
  assign mem_addr    = (state_q == ST_RUN) ? fetch_addr : waddr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;
  assign cpu_hold    = cpu_hold_q;
  assign cpu_restart = cpu_restart_q;
  assign loading     = (state_q != ST_RUN);
  assign word_count  = word_count_q;
  assign overflow    = overflow_q;

endmodule
